// File: rtl/matmul_pkg.sv
// Shared state type and arithmetic helpers for matmul_stream.
// The rounding helper works on a 64-bit signed value so one function serves every ACCW.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_OUTPUT
    } state_t;

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Round half up, then arithmetic shift; optionally clamp to a signed dw-bit range.
    function automatic logic signed [63:0] scale_round(input logic signed [63:0] acc,
                                                       input int frac,
                                                       input int dw,
                                                       input bit sat);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (frac > 0) begin
            r = r + (64'sd1 <<< (frac - 1));
        end
        r  = r >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sat) begin
            if (r > hi) begin
                r = hi;
            end else if (r < lo) begin
                r = lo;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed DW x DW multiply feeding an ACCW-bit accumulator; clear has priority over enable.
// sum exposes acc + a*b so the caller can capture the final term without an extra cycle.
module matmul_mac #(
    parameter int DW   = 16,
    parameter int ACCW = 35
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] sum
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc;

    assign prod = (2*DW)'(a) * (2*DW)'(b);
    assign sum  = acc + ACCW'(prod);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_stream.sv
// Streaming N x N signed fixed-point matrix multiplier: buffers A and B frames, emits C row-major.
// Define MATMUL_SAT_EN to clamp results to DW bits; otherwise results wrap.
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int N    = 8,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          s_axis_a_tvalid,
    output logic          s_axis_a_tready,
    input  logic [DW-1:0] s_axis_a_tdata,
    input  logic          s_axis_a_tlast,
    input  logic          s_axis_b_tvalid,
    output logic          s_axis_b_tready,
    input  logic [DW-1:0] s_axis_b_tdata,
    input  logic          s_axis_b_tlast,
    output logic          m_axis_c_tvalid,
    input  logic          m_axis_c_tready,
    output logic [DW-1:0] m_axis_c_tdata,
    output logic          m_axis_c_tlast,
    output logic          err_tlast,
    output logic          busy
);

    localparam int NN   = N * N;
    localparam int ACCW = acc_width(DW, N);
    localparam int CW   = $clog2(NN + 1);
    localparam int AW   = $clog2(NN);
    localparam int IW   = $clog2(N);
    localparam logic [CW-1:0] CNT_FULL = CW'(NN);
    localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_t              state;
    logic [CW-1:0]       a_cnt;
    logic [CW-1:0]       b_cnt;
    logic [IW-1:0]       i;
    logic [IW-1:0]       j;
    logic [IW-1:0]       k;
    logic [DW-1:0]       abuf [NN];
    logic [DW-1:0]       bbuf [NN];
    logic [AW-1:0]       a_addr;
    logic [AW-1:0]       b_addr;
    logic                a_fire;
    logic                b_fire;
    logic                mac_clr;
    logic                mac_en;
    logic signed [ACCW-1:0] mac_sum;
    logic [DW-1:0]       c_data;

    assign s_axis_a_tready = (state == ST_LOAD) && (a_cnt < CNT_FULL);
    assign s_axis_b_tready = (state == ST_LOAD) && (b_cnt < CNT_FULL);
    assign a_fire          = s_axis_a_tvalid && s_axis_a_tready;
    assign b_fire          = s_axis_b_tvalid && s_axis_b_tready;
    assign busy            = (state != ST_LOAD);

    always_ff @(posedge aclk) begin
        if (a_fire) begin
            abuf[a_cnt[AW-1:0]] <= s_axis_a_tdata;
        end
        if (b_fire) begin
            bbuf[b_cnt[AW-1:0]] <= s_axis_b_tdata;
        end
    end

    assign a_addr = AW'(i) * AW'(N) + AW'(k);
    assign b_addr = AW'(k) * AW'(N) + AW'(j);

    // The accumulator is cleared on the last MAC because its result is captured into tdata that cycle.
    assign mac_en  = (state == ST_COMPUTE);
    assign mac_clr = (state != ST_COMPUTE) || (k == IDX_LAST);

    matmul_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       ($signed(abuf[a_addr])),
        .b       ($signed(bbuf[b_addr])),
        .sum     (mac_sum)
    );

`ifdef MATMUL_SAT_EN
    assign c_data = DW'(scale_round(64'(mac_sum), FRAC, DW, 1'b1));
`else
    assign c_data = DW'(scale_round(64'(mac_sum), FRAC, DW, 1'b0));
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_LOAD;
            a_cnt           <= '0;
            b_cnt           <= '0;
            i               <= '0;
            j               <= '0;
            k               <= '0;
            m_axis_c_tvalid <= 1'b0;
            m_axis_c_tdata  <= '0;
            m_axis_c_tlast  <= 1'b0;
            err_tlast       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (a_fire) begin
                        a_cnt <= a_cnt + CW'(1);
                        if (s_axis_a_tlast != (a_cnt == CNT_LAST)) begin
                            err_tlast <= 1'b1;
                        end
                    end
                    if (b_fire) begin
                        b_cnt <= b_cnt + CW'(1);
                        if (s_axis_b_tlast != (b_cnt == CNT_LAST)) begin
                            err_tlast <= 1'b1;
                        end
                    end
                    if ((a_cnt == CNT_FULL) && (b_cnt == CNT_FULL)) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (k == IDX_LAST) begin
                        k               <= '0;
                        m_axis_c_tdata  <= c_data;
                        m_axis_c_tvalid <= 1'b1;
                        m_axis_c_tlast  <= (i == IDX_LAST) && (j == IDX_LAST);
                        state           <= ST_OUTPUT;
                    end else begin
                        k <= k + IW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (m_axis_c_tready) begin
                        m_axis_c_tvalid <= 1'b0;
                        m_axis_c_tlast  <= 1'b0;
                        if (j == IDX_LAST) begin
                            j <= '0;
                            if (i == IDX_LAST) begin
                                i     <= '0;
                                a_cnt <= '0;
                                b_cnt <= '0;
                                state <= ST_LOAD;
                            end else begin
                                i     <= i + IW'(1);
                                state <= ST_COMPUTE;
                            end
                        end else begin
                            j     <= j + IW'(1);
                            state <= ST_COMPUTE;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
